// File: rtl/seq_multiplier_if.sv
// rtl/seq_multiplier_if.sv - start/operand/result bundle for seq_multiplier
interface seq_multiplier_if #(
  parameter int WIDTH = 32
);
  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (output start, a, b, input busy, done, product);
  modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - shift-add unsigned multiplier, one bit per cycle, CLA accumulate adder
// SEQ_MULTIPLIER_EARLY_TERM_EN: stop as soon as the remaining multiplier bits are all zero
module cl_adder_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_i,
  output logic [3:0] s,
  output logic       g_o,
  output logic       p_o
);
  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g    = a & b;
  assign p    = a ^ b;
  assign c[0] = c_i;
  assign c[1] = g[0] | (p[0] & c_i);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_i);
  assign s    = p ^ c;
  assign g_o  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign p_o  = &p;
endmodule

module cla_gen_4 (
  input  logic [3:0] g,
  input  logic [3:0] p,
  input  logic       c_i,
  output logic [3:1] c,
  output logic       g_o,
  output logic       p_o
);
  assign c[1] = g[0] | (p[0] & c_i);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_i);
  assign g_o  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign p_o  = &p;
endmodule

module seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  seq_multiplier_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);
  localparam int NS = WIDTH / 4;
  localparam int NG = (NS + 3) / 4;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic                 carry_q, carry_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic [WIDTH-1:0]     hi;
  logic [WIDTH-1:0]     add_sum;
  logic                 add_cout;
  logic                 add_cin;
  logic [WIDTH:0]       acc;
  logic [2*WIDTH:0]     shifted;

  // Slice-level and group-level lookahead; padded slots propagate so the top group g_o is the carry-out
  logic [4*NG-1:0]      sg, sp, sc;
  logic [3:0]           gg, gp;
  logic [3:1]           top_c;
  logic                 top_g, top_p;
  logic [3:0]           gcin;
  logic                 unused_carry;

  assign hi      = prod_q[2*WIDTH-1:WIDTH];
  assign add_cin = 1'b0;
  assign gcin    = {top_c, add_cin};

  for (genvar i = 0; i < 4*NG; i++) begin : g_slice
    if (i < NS) begin : g_real
      cl_adder_4 u_add (
        .a   (hi[4*i +: 4]),
        .b   (mcand_q[4*i +: 4]),
        .c_i (sc[i]),
        .s   (add_sum[4*i +: 4]),
        .g_o (sg[i]),
        .p_o (sp[i])
      );
    end else begin : g_pad
      assign sg[i] = 1'b0;
      assign sp[i] = 1'b1;
    end
  end

  for (genvar j = 0; j < 4; j++) begin : g_group
    if (j < NG) begin : g_real
      logic [3:1] c;
      cla_gen_4 u_cla (
        .g   (sg[4*j +: 4]),
        .p   (sp[4*j +: 4]),
        .c_i (gcin[j]),
        .c   (c),
        .g_o (gg[j]),
        .p_o (gp[j])
      );
      assign sc[4*j]       = gcin[j];
      assign sc[4*j+1 +: 3] = c;
    end else begin : g_pad
      assign gg[j] = 1'b0;
      assign gp[j] = 1'b1;
    end
  end

  cla_gen_4 u_cla_top (
    .g   (gg),
    .p   (gp),
    .c_i (add_cin),
    .c   (top_c),
    .g_o (top_g),
    .p_o (top_p)
  );

  assign add_cout     = top_g | (top_p & add_cin);
  assign unused_carry = ^{gcin, sc};

`ifdef SEQ_MULTIPLIER_EARLY_TERM_EN
  logic [WIDTH-1:0] live_mask;
  logic [CW:0]      term_shift;
  logic             early_term;

  assign live_mask  = {WIDTH{1'b1}} >> cnt_q;
  assign early_term = (prod_q[WIDTH-1:0] & live_mask) == '0;
  assign term_shift = (CW+1)'(WIDTH) - {1'b0, cnt_q};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      mcand_q <= '0;
      prod_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    acc     = prod_q[0] ? {add_cout, add_sum} : {carry_q, hi};
    shifted = {acc, prod_q[WIDTH-1:0]} >> 1;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mcand_d = bus.a;
          prod_d  = {{WIDTH{1'b0}}, bus.b};
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
`ifdef SEQ_MULTIPLIER_EARLY_TERM_EN
        if (early_term) begin
          prod_d  = prod_q >> term_shift;
          carry_d = 1'b0;
          state_d = DONE;
        end else
`endif
        begin
          carry_d = shifted[2*WIDTH];
          prod_d  = shifted[2*WIDTH-1:0];
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = (state_q == DONE);
  assign bus.product = prod_q;
endmodule
